// File: rtl/hazard_unit.sv
// hazard_unit: load-use and multdiv interlock for the 5-stage core.
// Decodes the F/D and D/X instructions, tracks one in-flight mul/div and drives freeze/bubble.
module hazard_unit #(
    parameter int unsigned INSN_W     = 32,
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned MD_LAT     = 32,
    parameter bit          USE_RDY    = 1'b1,
    parameter int unsigned STATUS_REG = 30
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [INSN_W-1:0]   ir_fd,
    input  logic [INSN_W-1:0]   ir_dx,
    input  logic                md_rdy,
    output logic                stall,
    output logic                bubble_dx,
    output logic                md_start,
    output logic                md_busy,
    output logic [REG_BITS-1:0] md_rd
);

    localparam int unsigned RD_LSB = 22;
    localparam int unsigned RS_LSB = 17;
    localparam int unsigned RT_LSB = 12;
    localparam int unsigned AL_LSB = 2;
    localparam int unsigned CNT_W  = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MD_LAT - 1);
    localparam logic [REG_BITS-1:0] STATUS  = REG_BITS'(STATUS_REG);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic                src_a_v;
        logic [REG_BITS-1:0] src_a;
        logic                src_b_v;
        logic [REG_BITS-1:0] src_b;
        logic                src_b_st;
        logic                wr_v;
        logic [REG_BITS-1:0] wr;
        logic                is_load;
        logic                is_md;
    } dec_t;

    function automatic dec_t decode(input logic [INSN_W-1:0] ir);
        logic [4:0]          op;
        logic [4:0]          alu;
        logic [REG_BITS-1:0] rd;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        dec_t                d;
        op  = ir[INSN_W-1 -: 5];
        alu = ir[AL_LSB +: 5];
        rd  = ir[RD_LSB +: REG_BITS];
        rs  = ir[RS_LSB +: REG_BITS];
        rt  = ir[RT_LSB +: REG_BITS];
        d   = '0;
        case (op)
            OP_RTYPE: begin
                d.src_a_v = 1'b1;
                d.src_a   = rs;
                d.src_b_v = 1'b1;
                d.src_b   = rt;
                d.wr_v    = 1'b1;
                d.wr      = rd;
                d.is_md   = (alu == ALU_MUL) || (alu == ALU_DIV);
            end
            OP_ADDI: begin
                d.src_a_v = 1'b1;
                d.src_a   = rs;
                d.wr_v    = 1'b1;
                d.wr      = rd;
            end
            OP_LW: begin
                d.src_a_v = 1'b1;
                d.src_a   = rs;
                d.wr_v    = 1'b1;
                d.wr      = rd;
                d.is_load = 1'b1;
            end
            OP_SW: begin
                // store data rides the W->M bypass, so it is flagged separately from the base
                d.src_a_v  = 1'b1;
                d.src_a    = rs;
                d.src_b_v  = 1'b1;
                d.src_b    = rd;
                d.src_b_st = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                d.src_a_v = 1'b1;
                d.src_a   = rd;
                d.src_b_v = 1'b1;
                d.src_b   = rs;
            end
            OP_JR: begin
                d.src_a_v = 1'b1;
                d.src_a   = rd;
            end
            OP_BEX: begin
                d.src_a_v = 1'b1;
                d.src_a   = STATUS;
            end
            OP_JAL: begin
                d.wr_v = 1'b1;
                d.wr   = '1;
            end
            OP_SETX: begin
                d.wr_v = 1'b1;
                d.wr   = STATUS;
            end
            OP_J: begin
                d = '0;
            end
            default: begin
                d = '0;
            end
        endcase
        return d;
    endfunction

    function automatic logic reads(input dec_t d, input logic [REG_BITS-1:0] r,
                                   input logic skip_st);
        return (d.src_a_v && (d.src_a == r)) ||
               (d.src_b_v && !(skip_st && d.src_b_st) && (d.src_b == r));
    endfunction

    state_t              state_q, state_d;
    logic [REG_BITS-1:0] md_rd_q, md_rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    dec_t                fd_dec;
    dec_t                dx_dec;
    logic                busy;
    logic                done;
    logic                start;
    logic                pend;
    logic [REG_BITS-1:0] pend_rd;
    logic                ld_stall;
    logic                md_conflict;
    logic                md_stall;

    assign fd_dec = decode(ir_fd);
    assign dx_dec = decode(ir_dx);

    always_comb begin
        busy    = (state_q == BUSY);
        done    = busy && (USE_RDY ? md_rdy : (cnt_q == CNT_MAX));
        start   = dx_dec.is_md && !busy && !reset;
        pend    = busy || start;
        pend_rd = start ? dx_dec.wr : md_rd_q;

        ld_stall = dx_dec.is_load && (dx_dec.wr != '0) && reads(fd_dec, dx_dec.wr, 1'b1);

        md_conflict = ((pend_rd != '0) &&
                       (reads(fd_dec, pend_rd, 1'b0) ||
                        (fd_dec.wr_v && (fd_dec.wr == pend_rd)))) ||
                      fd_dec.is_md ||
                      reads(fd_dec, STATUS, 1'b0);
        md_stall    = pend && !done && md_conflict;
    end

    always_comb begin
        state_d = state_q;
        md_rd_d = md_rd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    md_rd_d = dx_dec.wr;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            md_rd_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            md_rd_q <= md_rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall     = !reset && (ld_stall || md_stall);
    assign bubble_dx = stall;
    assign md_start  = start;
    assign md_busy   = busy;
    assign md_rd     = md_rd_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one counter-timed instance (MD_LAT=4) and one md_rdy-timed instance.
module tb_hazard_unit;

    logic        clock;
    logic        reset;
    logic [31:0] ir_fd;
    logic [31:0] ir_dx;
    logic        md_rdy;

    logic       c_stall, c_bubble, c_start, c_busy;
    logic [4:0] c_rd;
    logic       r_stall, r_bubble, r_start, r_busy;
    logic [4:0] r_rd;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_unit #(.MD_LAT(4), .USE_RDY(1'b0)) u_cnt (
        .clock(clock), .reset(reset), .ir_fd(ir_fd), .ir_dx(ir_dx), .md_rdy(md_rdy),
        .stall(c_stall), .bubble_dx(c_bubble), .md_start(c_start),
        .md_busy(c_busy), .md_rd(c_rd)
    );

    hazard_unit #(.USE_RDY(1'b1)) u_rdy (
        .clock(clock), .reset(reset), .ir_fd(ir_fd), .ir_dx(ir_dx), .md_rdy(md_rdy),
        .stall(r_stall), .bubble_dx(r_bubble), .md_start(r_start),
        .md_busy(r_busy), .md_rd(r_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change on the falling edge; checks happen 1 time unit later
    task automatic drive(input logic [31:0] fd, input logic [31:0] dx,
                         input logic rdy, input logic rst);
        @(negedge clock);
        ir_fd  = fd;
        ir_dx  = dx;
        md_rdy = rdy;
        reset  = rst;
        #1;
    endtask

    logic [31:0] nop, lw_r3, lw_r0, add_r4, mul_r5, add_r6, div_r7, add_r8, mul_r9, bex_i;

    initial begin
        nop    = 32'd0;
        lw_r3  = i_ins(5'b01000, 5'd3, 5'd1);
        lw_r0  = i_ins(5'b01000, 5'd0, 5'd1);
        add_r4 = r_ins(5'd4, 5'd3, 5'd2, 5'd0);
        mul_r5 = r_ins(5'd5, 5'd2, 5'd3, 5'd6);
        add_r6 = r_ins(5'd6, 5'd5, 5'd1, 5'd0);
        div_r7 = r_ins(5'd7, 5'd1, 5'd2, 5'd7);
        add_r8 = r_ins(5'd8, 5'd1, 5'd2, 5'd0);
        mul_r9 = r_ins(5'd9, 5'd1, 5'd2, 5'd6);
        bex_i  = {5'b10110, 27'd0};

        reset = 1'b1; md_rdy = 1'b0; ir_fd = nop; ir_dx = nop;

        drive(nop, nop, 1'b0, 1'b1);
        chk("rst_stall", {31'd0, c_stall}, 32'd0);
        chk("rst_start", {31'd0, c_start}, 32'd0);
        drive(nop, nop, 1'b0, 1'b0);
        chk("rst_busy_c", {31'd0, c_busy}, 32'd0);
        chk("rst_busy_r", {31'd0, r_busy}, 32'd0);
        chk("rst_rd", {27'd0, c_rd}, 32'd0);

        // load-use
        drive(add_r4, lw_r3, 1'b0, 1'b0);
        chk("lu_stall", {31'd0, c_stall}, 32'd1);
        chk("lu_bubble", {31'd0, c_bubble}, 32'd1);
        chk("lu_stall_r", {31'd0, r_stall}, 32'd1);
        drive(add_r4, nop, 1'b0, 1'b0);
        chk("lu_release", {31'd0, c_stall}, 32'd0);
        drive(i_ins(5'b00111, 5'd3, 5'd5), lw_r3, 1'b0, 1'b0);
        chk("sw_data", {31'd0, c_stall}, 32'd0);
        drive(i_ins(5'b00111, 5'd6, 5'd3), lw_r3, 1'b0, 1'b0);
        chk("sw_base", {31'd0, c_stall}, 32'd1);
        drive(i_ins(5'b00010, 5'd3, 5'd1), lw_r3, 1'b0, 1'b0);
        chk("bne_rd", {31'd0, c_stall}, 32'd1);
        drive(i_ins(5'b00100, 5'd3, 5'd0), lw_r3, 1'b0, 1'b0);
        chk("jr_rd", {31'd0, c_stall}, 32'd1);
        drive(i_ins(5'b00001, 5'd3, 5'd3), lw_r3, 1'b0, 1'b0);
        chk("j_none", {31'd0, c_stall}, 32'd0);
        drive(r_ins(5'd4, 5'd0, 5'd0, 5'd0), lw_r0, 1'b0, 1'b0);
        chk("r0_exempt", {31'd0, c_stall}, 32'd0);

        // counter-timed mul, MD_LAT=4
        drive(nop, mul_r5, 1'b0, 1'b0);
        chk("mul_start", {31'd0, c_start}, 32'd1);
        chk("mul_indep", {31'd0, c_stall}, 32'd0);
        drive(add_r6, nop, 1'b0, 1'b0);
        chk("mul_start_once", {31'd0, c_start}, 32'd0);
        chk("mul_busy", {31'd0, c_busy}, 32'd1);
        chk("mul_rd", {27'd0, c_rd}, 32'd5);
        chk("raw_c0", {31'd0, c_stall}, 32'd1);
        drive(add_r6, nop, 1'b0, 1'b0);
        chk("raw_c1", {31'd0, c_stall}, 32'd1);
        drive(add_r6, nop, 1'b0, 1'b0);
        chk("raw_c2", {31'd0, c_stall}, 32'd1);
        drive(add_r6, nop, 1'b0, 1'b0);
        chk("raw_c3_done", {31'd0, c_stall}, 32'd0);
        chk("raw_c3_busy", {31'd0, c_busy}, 32'd1);
        drive(nop, add_r6, 1'b0, 1'b0);
        chk("mul_idle", {31'd0, c_busy}, 32'd0);
        chk("mul_idle_start", {31'd0, c_start}, 32'd0);

        // md_rdy-timed div with independent add then a mul
        drive(nop, nop, 1'b0, 1'b1);
        drive(nop, div_r7, 1'b0, 1'b0);
        chk("div_start", {31'd0, r_start}, 32'd1);
        drive(add_r8, nop, 1'b0, 1'b0);
        chk("div_busy", {31'd0, r_busy}, 32'd1);
        chk("div_rd", {27'd0, r_rd}, 32'd7);
        chk("indep_add", {31'd0, r_stall}, 32'd0);
        drive(mul_r9, add_r8, 1'b0, 1'b0);
        chk("md_in_fd", {31'd0, r_stall}, 32'd1);
        chk("md_no_restart", {31'd0, r_start}, 32'd0);
        drive(mul_r9, nop, 1'b0, 1'b0);
        chk("md_hold", {31'd0, r_stall}, 32'd1);
        drive(mul_r9, nop, 1'b1, 1'b0);
        chk("rdy_release", {31'd0, r_stall}, 32'd0);
        drive(nop, mul_r9, 1'b0, 1'b0);
        chk("mul2_start", {31'd0, r_start}, 32'd1);
        chk("mul2_idle", {31'd0, r_busy}, 32'd0);
        drive(i_ins(5'b00101, 5'd9, 5'd1), nop, 1'b0, 1'b0);
        chk("waw", {31'd0, r_stall}, 32'd1);
        chk("mul2_rd", {27'd0, r_rd}, 32'd9);
        drive(nop, nop, 1'b1, 1'b0);
        drive(nop, nop, 1'b1, 1'b0);
        chk("rdy_idle_ignored", {31'd0, r_busy}, 32'd0);

        // reset while busy with bex waiting on the status register
        drive(nop, mul_r5, 1'b0, 1'b0);
        chk("t6_start", {31'd0, r_start}, 32'd1);
        drive(bex_i, nop, 1'b0, 1'b0);
        chk("bex_stall", {31'd0, r_stall}, 32'd1);
        drive(add_r4, lw_r3, 1'b0, 1'b1);
        chk("rst_forces_stall", {31'd0, r_stall}, 32'd0);
        drive(bex_i, nop, 1'b0, 1'b0);
        chk("t6_busy", {31'd0, r_busy}, 32'd0);
        chk("t6_stall", {31'd0, r_stall}, 32'd0);
        chk("t6_nostart", {31'd0, r_start}, 32'd0);
        drive(nop, mul_r5, 1'b0, 1'b0);
        chk("t6_restart", {31'd0, r_start}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
